// File: rtl/cpu_stage4.sv
`default_nettype none
// ============================================================================
// Module      : cpu_stage4
// Description : Parametrised accumulator CPU with a writable program RAM,
//               run/halt control, a multi-cycle WAIT instruction and PC/halt
//               status outputs. Each instruction takes FETCH + EXEC; WAIT adds
//               imm stall cycles.
// Ports       : clk        - single clock, rising edge
//               reset      - synchronous, active-high
//               run        - 1 = execute; sampled at instruction boundaries
//               prog_we    - program RAM write strobe (any state)
//               prog_addr  - program RAM write address
//               prog_data  - instruction word {opcode[3:0], imm[DATA_W-1:0]}
//               led        - output register written by OUT
//               pc         - current program counter
//               halted     - high while in the HALTED state
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_stage4 #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 4,
  parameter int OUT_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                prog_we,
  input  logic [PC_W-1:0]     prog_addr,
  input  logic [4+DATA_W-1:0] prog_data,
  output logic [OUT_W-1:0]    led,
  output logic [PC_W-1:0]     pc,
  output logic                halted
);

  localparam int c_IW    = 4 + DATA_W;
  localparam int c_DEPTH = 1 << PC_W;

  localparam logic [3:0] c_OP_NOP  = 4'h0;
  localparam logic [3:0] c_OP_LDI  = 4'h1;
  localparam logic [3:0] c_OP_ADDI = 4'h2;
  localparam logic [3:0] c_OP_SUBI = 4'h3;
  localparam logic [3:0] c_OP_ANDI = 4'h4;
  localparam logic [3:0] c_OP_XORI = 4'h5;
  localparam logic [3:0] c_OP_OUT  = 4'h6;
  localparam logic [3:0] c_OP_JMP  = 4'h7;
  localparam logic [3:0] c_OP_JNZ  = 4'h8;
  localparam logic [3:0] c_OP_JZ   = 4'h9;
  localparam logic [3:0] c_OP_WAIT = 4'hA;
  localparam logic [3:0] c_OP_HALT = 4'hB;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_WAIT   = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  // Program RAM: deliberately not reset so programs survive a reset.
  logic [c_IW-1:0]   r_mem [0:c_DEPTH-1];

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   w_pc_nxt;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] w_acc_nxt;
  logic [c_IW-1:0]   r_ir;
  logic [c_IW-1:0]   w_ir_nxt;
  logic [DATA_W-1:0] r_wait_cnt;
  logic [DATA_W-1:0] w_wait_nxt;
  logic [OUT_W-1:0]  r_led;
  logic [OUT_W-1:0]  w_led_nxt;

  logic [3:0]        w_op;
  logic [DATA_W-1:0] w_imm;
  logic [PC_W-1:0]   w_target;
  logic [PC_W-1:0]   w_pc_inc;
  state_t            w_after_instr;

  assign w_op     = r_ir[c_IW-1:DATA_W];
  assign w_imm    = r_ir[DATA_W-1:0];
  assign w_target = w_imm[PC_W-1:0];
  assign w_pc_inc = r_pc + PC_W'(1);

  // Where to go once an instruction (including any WAIT stall) is done.
  assign w_after_instr = run ? S_FETCH : S_IDLE;

  // Memory write port; the FETCH read uses the pre-edge contents, so a write
  // to the address being fetched in the same cycle is seen only next visit.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_acc      <= '0;
      r_ir       <= '0;
      r_wait_cnt <= '0;
      r_led      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_acc      <= w_acc_nxt;
      r_ir       <= w_ir_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_led      <= w_led_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_acc_nxt   = r_acc;
    w_ir_nxt    = r_ir;
    w_wait_nxt  = r_wait_cnt;
    w_led_nxt   = r_led;

    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_state_nxt = S_FETCH;
        end
      end

      S_FETCH: begin
        w_ir_nxt    = r_mem[r_pc];
        w_state_nxt = S_EXEC;
      end

      S_EXEC: begin
        w_pc_nxt    = w_pc_inc;
        w_state_nxt = w_after_instr;
        case (w_op)
          c_OP_NOP:  ;
          c_OP_LDI:  w_acc_nxt = w_imm;
          c_OP_ADDI: w_acc_nxt = r_acc + w_imm;
          c_OP_SUBI: w_acc_nxt = r_acc - w_imm;
          c_OP_ANDI: w_acc_nxt = r_acc & w_imm;
          c_OP_XORI: w_acc_nxt = r_acc ^ w_imm;
          c_OP_OUT:  w_led_nxt = r_acc[OUT_W-1:0];
          c_OP_JMP:  w_pc_nxt  = w_target;
          c_OP_JNZ:  if (r_acc != '0) w_pc_nxt = w_target;
          c_OP_JZ:   if (r_acc == '0) w_pc_nxt = w_target;
          c_OP_WAIT: begin
            // WAIT 0 behaves as a plain two-cycle instruction.
            if (w_imm != '0) begin
              w_wait_nxt  = w_imm - DATA_W'(1);
              w_state_nxt = S_WAIT;
            end
          end
          c_OP_HALT: begin
            // pc stays on the HALT so it reports the halting address.
            w_pc_nxt    = r_pc;
            w_state_nxt = S_HALTED;
          end
          default: ;
        endcase
      end

      S_WAIT: begin
        if (r_wait_cnt == '0) begin
          w_state_nxt = w_after_instr;
        end else begin
          w_wait_nxt = r_wait_cnt - DATA_W'(1);
        end
      end

      S_HALTED: ;

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign led    = r_led;
  assign pc     = r_pc;
  assign halted = (r_state == S_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_cpu_stage4.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_stage4
// Description : Directed self-checking bench for cpu_stage4 (default widths).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_stage4;

  localparam int c_DW = 8;
  localparam int c_PW = 4;
  localparam int c_OW = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              run;
  logic              prog_we;
  logic [c_PW-1:0]   prog_addr;
  logic [4+c_DW-1:0] prog_data;
  logic [c_OW-1:0]   led;
  logic [c_PW-1:0]   pc;
  logic              halted;

  always #5 clk = ~clk;

  cpu_stage4 #(.DATA_W(c_DW), .PC_W(c_PW), .OUT_W(c_OW)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .led       (led),
    .pc        (pc),
    .halted    (halted)
  );

  int             n_checks = 0;
  int             n_pass   = 0;
  int             cyc      = 0;
  logic [c_OW-1:0] prev_led;
  logic [c_OW-1:0] led_q[$];
  int             time_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // One clock; samples on the falling edge and logs every led change.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (led !== prev_led) begin
      led_q.push_back(led);
      time_q.push_back(cyc);
      prev_led = led;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_log();
    led_q.delete();
    time_q.delete();
    prev_led = led;
  endtask

  task automatic wr(input int addr, input logic [3:0] op, input logic [c_DW-1:0] imm);
    prog_we   = 1'b1;
    prog_addr = addr[c_PW-1:0];
    prog_data = {op, imm};
    tick();
    prog_we   = 1'b0;
  endtask

  // Enter reset (programs are loaded while reset is held).
  task automatic hold_reset();
    reset = 1'b1;
    run   = 1'b0;
    tick();
  endtask

  task automatic release_and_run();
    reset = 1'b0;
    tick();
    clear_log();
    run = 1'b1;
  endtask

  task automatic run_until_halt(input int budget, input string tag);
    int k = 0;
    while (halted !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    check({tag, " halt reached"}, halted, 1);
  endtask

  task automatic wait_pc(input logic [c_PW-1:0] val, input int budget, input string tag);
    int k = 0;
    while (pc !== val && k < budget) begin
      tick();
      k++;
    end
    check({tag, " pc reached"}, pc, val);
  endtask

  function automatic logic [c_OW-1:0] q_at(input int i);
    if (i < led_q.size()) return led_q[i];
    return 'x;
  endfunction

  function automatic int gap(input int i);
    if (i + 1 < time_q.size()) return time_q[i+1] - time_q[i];
    return -1;
  endfunction

  task automatic check_seq3(input string tag, input logic [c_OW-1:0] e0, e1, e2);
    check({tag, " led count"}, led_q.size(), 3);
    check({tag, " led[0]"}, q_at(0), e0);
    check({tag, " led[1]"}, q_at(1), e1);
    check({tag, " led[2]"}, q_at(2), e2);
  endtask

  task automatic load_countdown();
    wr(0, 4'h1, 8'd3);   // LDI 3
    wr(1, 4'h6, 8'd0);   // OUT
    wr(2, 4'h3, 8'd1);   // SUBI 1
    wr(3, 4'h8, 8'd1);   // JNZ 1
    wr(4, 4'hB, 8'd0);   // HALT
  endtask

  // OUT / ADDI / WAIT imm / OUT; gap between the two led writes is
  // ADDI(2) + WAIT(2+imm) + OUT(2).
  task automatic wait_case(input logic [c_DW-1:0] imm, input int exp_gap, input string tag);
    hold_reset();
    wr(0, 4'h1, 8'd1);
    wr(1, 4'h6, 8'd0);
    wr(2, 4'h2, 8'd1);
    wr(3, 4'hA, imm);
    wr(4, 4'h6, 8'd0);
    wr(5, 4'hB, 8'd0);
    release_and_run();
    run_until_halt(100, tag);
    check({tag, " led count"}, led_q.size(), 2);
    check({tag, " gap"}, gap(0), exp_gap);
    check({tag, " pc"}, pc, 5);
  endtask

  initial begin
    reset     = 1'b1;
    run       = 1'b0;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    prev_led  = '0;
    ticks(2);

    // ---------------- Countdown ----------------
    load_countdown();
    reset = 1'b0;
    tick();
    clear_log();
    check("reset led", led, 0);
    check("reset pc", pc, 0);
    check("reset halted", halted, 0);
    ticks(3);
    check("idle holds pc", pc, 0);
    run = 1'b1;
    run_until_halt(200, "countdown");
    check_seq3("countdown", 8'd3, 8'd2, 8'd1);
    check("countdown loop gap", gap(0), 6);
    check("countdown pc", pc, 4);
    check("countdown led", led, 1);
    run = 1'b0;
    ticks(5);
    check("halted holds", halted, 1);
    check("halted pc holds", pc, 4);

    // ---------------- Reset from HALTED and mid-run ----------------
    reset = 1'b1;
    tick();
    check("reset from halt halted", halted, 0);
    check("reset from halt pc", pc, 0);
    check("reset from halt led", led, 0);
    run = 1'b1;
    reset = 1'b0;
    tick();
    begin
      int k = 0;
      while (led !== 8'd2 && k < 100) begin
        tick();
        k++;
      end
    end
    check("midrun led reached 2", led, 2);
    reset = 1'b1;
    tick();
    check("midrun reset led", led, 0);
    check("midrun reset pc", pc, 0);
    check("midrun reset halted", halted, 0);
    reset = 1'b0;
    run   = 1'b0;
    ticks(4);
    check("post reset idle pc", pc, 0);
    clear_log();
    run = 1'b1;
    run_until_halt(200, "rerun");
    check_seq3("rerun", 8'd3, 8'd2, 8'd1);

    // ---------------- ALU ops, JZ/JNZ, unknown opcode ----------------
    hold_reset();
    wr(0,  4'h1, 8'hF0);   // LDI F0
    wr(1,  4'h5, 8'h3C);   // XORI -> CC
    wr(2,  4'h6, 8'h00);   // OUT CC
    wr(3,  4'h4, 8'h0F);   // ANDI -> 0C
    wr(4,  4'h6, 8'h00);   // OUT 0C
    wr(5,  4'h3, 8'h0C);   // SUBI -> 00
    wr(6,  4'h9, 8'h09);   // JZ 9 (taken)
    wr(7,  4'h1, 8'hEE);
    wr(8,  4'h6, 8'h00);
    wr(9,  4'hC, 8'h55);   // undefined -> NOP
    wr(10, 4'h3, 8'h01);   // SUBI -> FF (wraps)
    wr(11, 4'h8, 8'h0D);   // JNZ 13 (taken)
    wr(12, 4'h6, 8'h00);
    wr(13, 4'h6, 8'h00);   // OUT FF
    wr(14, 4'hB, 8'h00);   // HALT
    release_and_run();
    run_until_halt(300, "alu");
    check_seq3("alu", 8'hCC, 8'h0C, 8'hFF);
    check("alu pc", pc, 14);

    // ---------------- PC wrap ----------------
    hold_reset();
    wr(0, 4'h1, 8'hFF);
    wr(1, 4'h2, 8'h02);
    wr(2, 4'h6, 8'h00);
    for (int a = 3; a < 16; a++) wr(a, 4'h0, 8'h00);
    release_and_run();
    wait_pc(4'd15, 100, "wrap");
    ticks(2);
    check("wrap pc to 0", pc, 0);
    check("wrap led", led, 8'h01);
    ticks(70);
    check("wrap led stable", led, 8'h01);
    check("wrap single led change", led_q.size(), 1);
    check("wrap not halted", halted, 0);

    // ---------------- WAIT timing ----------------
    wait_case(8'd5, 11, "wait5");
    wait_case(8'd1, 7,  "wait1");
    wait_case(8'd0, 6,  "wait0");

    // ---------------- Pause during WAIT ----------------
    hold_reset();
    wr(0, 4'h1, 8'd1);
    wr(1, 4'h6, 8'd0);
    wr(2, 4'h2, 8'd1);
    wr(3, 4'hA, 8'd5);
    wr(4, 4'h6, 8'd0);
    wr(5, 4'h2, 8'd1);
    wr(6, 4'h6, 8'd0);
    wr(7, 4'hB, 8'd0);
    release_and_run();
    wait_pc(4'd4, 100, "pause");
    run = 1'b0;
    ticks(20);
    check("pause pc frozen", pc, 4);
    check("pause led", led, 1);
    check("pause not halted", halted, 0);
    run = 1'b1;
    ticks(2);
    check("resume led before OUT", led, 1);
    tick();
    check("resume led after OUT", led, 2);
    run_until_halt(100, "pause");
    check_seq3("pause", 8'd1, 8'd2, 8'd3);
    check("pause final pc", pc, 7);

    // ---------------- Write/fetch collision ----------------
    hold_reset();
    wr(0, 4'h1, 8'h11);
    wr(1, 4'h6, 8'h00);
    wr(2, 4'h7, 8'h00);    // JMP 0
    release_and_run();
    wait_pc(4'd2, 50, "collision");
    begin
      int k = 0;
      while (pc !== 4'd0 && k < 10) begin
        tick();
        k++;
      end
    end
    check("collision at fetch of 0", pc, 0);
    prog_we   = 1'b1;
    prog_addr = 4'd0;
    prog_data = {4'h1, 8'h22};
    tick();
    prog_we   = 1'b0;
    ticks(3);
    check("collision old word", led, 8'h11);
    ticks(6);
    check("collision new word", led, 8'h22);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
